// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg
// Shared definitions for alu_result_stage and its branch evaluator:
//   - state_t     : buffer occupancy (EMPTY, ONE, TWO)
//   - BR_*        : branch condition codes
//   - FLAG_*      : bit positions inside the {C,N,Z} flag vector
package alu_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [2:0] BR_NEVER  = 3'b000;
    localparam logic [2:0] BR_ALWAYS = 3'b001;
    localparam logic [2:0] BR_EQ     = 3'b010;
    localparam logic [2:0] BR_NE     = 3'b011;
    localparam logic [2:0] BR_LT     = 3'b100;
    localparam logic [2:0] BR_GE     = 3'b101;
    localparam logic [2:0] BR_CS     = 3'b110;
    localparam logic [2:0] BR_CC     = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

endpackage

// File: rtl/alu_result_stage_branch.sv
// branch_cond_eval
// Combinational branch condition evaluator.
// Ports:
//   flags [2:0] in  : {C,N,Z} flags the condition is tested against
//   cond  [2:0] in  : branch condition code (BR_*)
//   taken       out : condition outcome
module branch_cond_eval
    import alu_stage_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            BR_EQ:     taken = flags[FLAG_Z];
            BR_NE:     taken = !flags[FLAG_Z];
            BR_LT:     taken = flags[FLAG_N];
            BR_GE:     taken = !flags[FLAG_N];
            BR_CS:     taken = flags[FLAG_C];
            BR_CC:     taken = !flags[FLAG_C];
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered ALUOut buffer with architectural flag register and per-entry
// branch outcome, presented over a valid/ready handshake.
// Build option: define ALU_RESULT_SKID_EN for a two-entry skid buffer whose
// ready depends on state only; otherwise a single entry whose ready passes
// combinationally through input_wb_ready.
// Ports:
//   input_CLK, input_Reset_n         : clock, async active-low reset
//   input_ALU, input_Zero/Negative/Carry : ALU result and its flags
//   input_valid / output_ready       : capture handshake
//   input_FlagWrite                  : capture also updates flag register
//   input_BranchCond                 : condition evaluated for this capture
//   input_Flush                      : discard all buffered entries
//   output_ALUOut, output_BranchTaken, output_valid / input_wb_ready : head entry
//   output_Flags                     : flag register {C,N,Z}
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             input_CLK,
    input  logic             input_Reset_n,
    input  logic [WIDTH-1:0] input_ALU,
    input  logic             input_Zero,
    input  logic             input_Negative,
    input  logic             input_Carry,
    input  logic             input_valid,
    output logic             output_ready,
    input  logic             input_FlagWrite,
    input  logic [2:0]       input_BranchCond,
    input  logic             input_Flush,
    output logic [WIDTH-1:0] output_ALUOut,
    output logic             output_BranchTaken,
    output logic             output_valid,
    input  logic             input_wb_ready,
    output logic [2:0]       output_Flags
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] head_data_d;
    logic             head_taken_d;
    logic             valid_d;
    logic [2:0]       flags_d;
    logic [2:0]       new_flags;
    logic [2:0]       cond_flags;
    logic             new_taken;
    logic             push, pop;

`ifdef ALU_RESULT_SKID_EN
    logic [WIDTH-1:0] sec_data_q, sec_data_d;
    logic             sec_taken_q, sec_taken_d;

    assign output_ready = (state_q != TWO);
`else
    assign output_ready = !output_valid || input_wb_ready;
`endif

    assign push = input_valid && output_ready;
    assign pop  = output_valid && input_wb_ready;

    assign new_flags  = {input_Carry, input_Negative, input_Zero};
    // A flag-writing capture branches on its own flags, not the stale ones.
    assign cond_flags = input_FlagWrite ? new_flags : output_Flags;

    branch_cond_eval u_branch (
        .flags (cond_flags),
        .cond  (input_BranchCond),
        .taken (new_taken)
    );

    always_comb begin
        state_d      = state_q;
        head_data_d  = output_ALUOut;
        head_taken_d = output_BranchTaken;
`ifdef ALU_RESULT_SKID_EN
        sec_data_d   = sec_data_q;
        sec_taken_d  = sec_taken_q;
`endif
        flags_d      = output_Flags;

        if (input_Flush) begin
            state_d = EMPTY;
        end else begin
            if (push && input_FlagWrite) flags_d = new_flags;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        head_data_d  = input_ALU;
                        head_taken_d = new_taken;
                    end
                end
                ONE: begin
`ifdef ALU_RESULT_SKID_EN
                    if (push && pop) begin
                        head_data_d  = input_ALU;
                        head_taken_d = new_taken;
                    end else if (push) begin
                        state_d     = TWO;
                        sec_data_d  = input_ALU;
                        sec_taken_d = new_taken;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
`else
                    if (push) begin
                        head_data_d  = input_ALU;
                        head_taken_d = new_taken;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
`endif
                end
`ifdef ALU_RESULT_SKID_EN
                TWO: begin
                    if (pop) begin
                        state_d      = ONE;
                        head_data_d  = sec_data_q;
                        head_taken_d = sec_taken_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end

        valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            state_q            <= EMPTY;
            output_valid       <= 1'b0;
            output_ALUOut      <= '0;
            output_BranchTaken <= 1'b0;
            output_Flags       <= 3'b000;
`ifdef ALU_RESULT_SKID_EN
            sec_data_q         <= '0;
            sec_taken_q        <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            output_valid       <= valid_d;
            output_ALUOut      <= head_data_d;
            output_BranchTaken <= head_taken_d;
            output_Flags       <= flags_d;
`ifdef ALU_RESULT_SKID_EN
            sec_data_q         <= sec_data_d;
            sec_taken_q        <= sec_taken_d;
`endif
        end
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered stage directly downstream of the ALU in the 16-bit multi-cycle datapath. It captures the ALU result and its Z/N/C flags into an ALUOut buffer and holds the architectural flag register. For each captured result it evaluates a branch condition. Results are presented to the write-back/PC-update logic over a valid/ready handshake, with an optional second skid entry.

## Interface
- WIDTH, 16, datapath width of result and buffer entries
- input_CLK  in  1  sole clock, rising edge
- input_Reset_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- input_ALU  in  WIDTH  ALU result
- input_Zero, input_Negative, input_Carry  in  1 each  ALU flags for input_ALU
- input_valid  in  1  control asserts: ALU result this cycle is to be captured
- output_ready  out  1  stage can accept a capture this cycle
- input_FlagWrite  in  1  with a capture, update the flag register
- input_BranchCond  in  3  condition evaluated for this capture
- input_Flush  in  1  discard all buffered entries
- output_ALUOut  out  WIDTH  head-entry result
- output_BranchTaken  out  1  head-entry condition outcome
- output_valid  out  1  head entry valid
- input_wb_ready  in  1  consumer accepts head entry
- output_Flags  out  3  flag register {C,N,Z}

## Operation
- Push = input_valid && output_ready. Pop = output_valid && input_wb_ready.
- Flag register:
  - On a push with input_FlagWrite=1, load {input_Carry,input_Negative,input_Zero}.
  - Otherwise hold.
  - Flags are architectural state and are not queued.
- Condition flags for a push:
  - New flags when input_FlagWrite=1.
  - Current flag register otherwise.
- Branch condition codes:
  - 000 never
  - 001 always
  - 010 EQ (Z)
  - 011 NE (!Z)
  - 100 LT (N)
  - 101 GE (!N)
  - 110 CS (C)
  - 111 CC (!C)
- Each entry stores {result, taken}.
- FSM states (skid build): EMPTY, ONE, TWO.
  - output_ready = (state != TWO). Derived from state only, with no path from input_wb_ready.
  - EMPTY: push -> ONE.
  - ONE, push only -> TWO.
  - ONE, pop only -> EMPTY.
  - ONE, push+pop -> ONE, and the head takes the new entry.
  - TWO: pop -> ONE, and the second entry moves to the head. Push is impossible because ready=0.
- Flush:
  - Next state is EMPTY.
  - A simultaneous push is dropped, including its flag update.
  - Flush beats pop.
  - Flag register is otherwise unaffected.
- Reset: state EMPTY, output_valid=0, output_ALUOut=0, output_BranchTaken=0, output_Flags=3'b000, output_ready=1 after release.
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge.

## Timing
- Capture on the rising edge. output_valid, output_ALUOut and output_BranchTaken are valid the following cycle, giving 1-cycle latency.
- output_Flags changes on the edge of a flag-writing push.
- All outputs are registered except output_ready. output_ready is decoded from the state register only.
- output_ALUOut and output_BranchTaken must stay stable while output_valid=1 and input_wb_ready=0.
- Sustained throughput: 1 result/cycle when input_wb_ready is held high.

## Configuration
- Macro `ALU_RESULT_SKID_EN`.
- Defined: two-entry buffer with the FSM described above.
- Undefined: single entry, with states EMPTY and ONE.
  - output_ready = !output_valid || input_wb_ready. This is combinational through input_wb_ready.
  - ONE with push+pop replaces the head.
  - There is no TWO state.
- Flag and branch behaviour is identical in both builds.

## Structure
- Package alu_stage_pkg holds:
  - State encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Branch condition localparams: BR_NEVER … BR_CC.
  - Flag bit indices: FLAG_Z=0, FLAG_N=1, FLAG_C=2.
- Sub-module branch_cond_eval: combinational, inputs (flags[2:0], cond[2:0]), output taken. It is instantiated once, on the capture path.

## Test plan
- Reset, then push A=16'h0000, Z=1, FlagWrite=1, cond=010 -> next cycle output_valid=1, output_ALUOut=0000, output_BranchTaken=1, output_Flags=3'b001.
- Push 16'h8001, N=1, FlagWrite=0, cond=100 with flags 3'b000 -> taken=0, output_Flags unchanged.
- input_wb_ready=0; push 1111, then 2222 -> output_ready=0 after the second push, and a third push is ignored. Raise wb_ready -> 1111 then 2222 on consecutive cycles, then output_valid=0.
- Back-to-back pushes 0001…0008 with wb_ready=1 -> 8 pops on consecutive cycles, in order.
- Two entries held, assert input_Flush together with a push of 3333 and FlagWrite=1 -> next cycle output_valid=0, output_ready=1, flags unchanged.
- Two entries held, drop input_Reset_n between clock edges -> output_valid=0 and output_Flags=000 immediately. Rebuild without `ALU_RESULT_SKID_EN` -> output_ready follows wb_ready while full.
